// File: rtl/qam_frame_pkg.sv
// Shared types and constants for the QAM frame scheduler.
package qam_frame_pkg;

    typedef logic [3:0] sym_t;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        PAY,
        GAP
    } frame_state_t;

    localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

endpackage

// File: rtl/qam_frame_ctrl.sv
// Frame scheduler in front of qam_top: preamble, FRAME_LEN payload symbols, idle gap.
// Optional pilot insertion into the payload is enabled by defining QAM_FRAME_PILOT_EN.
module qam_frame_ctrl
    import qam_frame_pkg::*;
#(
    parameter int         PRE_LEN        = 4,
    parameter int         FRAME_LEN      = 64,
    parameter int         GAP_LEN        = 8,
    parameter logic [3:0] PRE_SYM_A      = 4'h0,
    parameter logic [3:0] PRE_SYM_B      = 4'hF,
    parameter int         PILOT_INTERVAL = 16,
    parameter logic [3:0] PILOT_SYM      = 4'h5
) (
    input  logic        axi_clk,
    input  logic        axi_rst,
    input  logic        start,
    input  logic        s_valid,
    input  logic [3:0]  s_data,
    output logic        s_ready,
    output logic        din_valid,
    output logic [3:0]  din,
    input  logic        din_ready,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] underrun_cnt
);

    localparam int IW = $clog2(PRE_LEN) + 1;
    localparam int AW = $clog2(FRAME_LEN + 1);
    localparam int GW = $clog2(GAP_LEN + 1) + 1;
    localparam logic [IW-1:0] PRE_LAST = IW'(PRE_LEN - 1);
    localparam logic [AW-1:0] ACC_FULL = AW'(FRAME_LEN);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LEN - 1);

    if (PRE_LEN < 1 || FRAME_LEN < 1 || GAP_LEN < 0 || PILOT_INTERVAL < 1) begin : g_param_check
        $error("qam_frame_ctrl: illegal parameter value");
    end

    frame_state_t state_reg, state_next;
    logic [IW-1:0] pre_idx_reg;
    logic [AW-1:0] acc_cnt_reg;
    logic [GW-1:0] gap_cnt_reg;
    sym_t          din_reg;
    logic          din_valid_reg;
    logic [15:0]   underrun_reg;

    logic out_xfer, slot_free, pre_last_xfer, pay_open, s_ready_int, accept;
    logic pay_done, pilot_due, pilot_load, underrun_hit, frame_done_int;

`ifdef QAM_FRAME_PILOT_EN
    localparam int PW = $clog2(PILOT_INTERVAL + 1);
    localparam logic [PW-1:0] PILOT_AT = PW'(PILOT_INTERVAL);
    logic [PW-1:0] pilot_cnt_reg;
    // Never due once the last payload symbol has been accepted.
    assign pilot_due = (state_reg == PAY) && (pilot_cnt_reg == PILOT_AT) && (acc_cnt_reg < ACC_FULL);
`else
    assign pilot_due = 1'b0;
`endif

    assign out_xfer      = din_valid_reg && din_ready;
    assign slot_free     = !din_valid_reg || din_ready;
    // Payload is pulled already on the last preamble handoff so the stream has no bubble.
    assign pre_last_xfer = (state_reg == PRE) && out_xfer && (pre_idx_reg == PRE_LAST);
    assign pay_open      = (acc_cnt_reg < ACC_FULL) && !pilot_due;
    assign s_ready_int   = pay_open && slot_free && ((state_reg == PAY) || pre_last_xfer);
    assign accept        = s_valid && s_ready_int;
    assign pay_done      = (state_reg == PAY) && (acc_cnt_reg == ACC_FULL) && out_xfer;
    assign pilot_load    = (state_reg == PAY) && pilot_due && slot_free;
    assign underrun_hit  = (state_reg == PAY) && slot_free && !s_valid && pay_open;

    always_comb begin
        state_next     = state_reg;
        frame_done_int = 1'b0;
        case (state_reg)
            IDLE: if (start) state_next = PRE;
            PRE:  if (pre_last_xfer) state_next = PAY;
            PAY: begin
                if (pay_done) begin
                    if (GAP_LEN > 0) begin
                        state_next = GAP;
                    end else begin
                        state_next     = IDLE;
                        frame_done_int = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next     = IDLE;
                    frame_done_int = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            state_reg     <= IDLE;
            pre_idx_reg   <= '0;
            acc_cnt_reg   <= '0;
            gap_cnt_reg   <= '0;
            din_reg       <= '0;
            din_valid_reg <= 1'b0;
            underrun_reg  <= '0;
`ifdef QAM_FRAME_PILOT_EN
            pilot_cnt_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;

            // Output register: payload, pilot, next preamble symbol, or drain on handoff.
            if (accept) begin
                din_reg       <= s_data;
                din_valid_reg <= 1'b1;
            end else if (pilot_load) begin
                din_reg       <= PILOT_SYM;
                din_valid_reg <= 1'b1;
            end else if ((state_reg == PRE) && out_xfer && !pre_last_xfer) begin
                din_reg       <= pre_idx_reg[0] ? PRE_SYM_A : PRE_SYM_B;
                din_valid_reg <= 1'b1;
            end else if ((state_reg == IDLE) && start) begin
                din_reg       <= PRE_SYM_A;
                din_valid_reg <= 1'b1;
            end else if (out_xfer) begin
                din_valid_reg <= 1'b0;
            end

            if (state_reg == IDLE)
                pre_idx_reg <= '0;
            else if ((state_reg == PRE) && out_xfer)
                pre_idx_reg <= pre_idx_reg + 1'b1;

            if (state_reg == IDLE)
                acc_cnt_reg <= '0;
            else if (accept)
                acc_cnt_reg <= acc_cnt_reg + 1'b1;

            if (state_reg == GAP)
                gap_cnt_reg <= gap_cnt_reg + 1'b1;
            else
                gap_cnt_reg <= '0;

            if (underrun_hit && (underrun_reg != UNDERRUN_MAX))
                underrun_reg <= underrun_reg + 1'b1;

`ifdef QAM_FRAME_PILOT_EN
            if ((state_reg == IDLE) || pilot_load)
                pilot_cnt_reg <= '0;
            else if (accept)
                pilot_cnt_reg <= pilot_cnt_reg + 1'b1;
`endif
        end
    end

    assign s_ready      = s_ready_int;
    assign din_valid    = din_valid_reg;
    assign din          = din_reg;
    assign busy         = (state_reg != IDLE);
    assign frame_done   = frame_done_int;
    assign underrun_cnt = underrun_reg;

endmodule
